// File: rtl/router_pkt_tx.sv
// Router input-port packet transmitter: buffers one request's payload, then sends
// header, payload and parity to the router, holding each byte while busy is high.
module router_pkt_tx #(
    parameter int MAX_LEN = 63
) (
    input  logic                               clock_i,
    input  logic                               resetn_i,
    input  logic                               start_i,
    input  logic [1:0]                         dest_addr_i,
    input  logic [$clog2(MAX_LEN+1)-1:0]       pay_len_i,
    output logic                               req_ready_o,
    output logic                               req_err_o,
    input  logic [7:0]                         pl_data_i,
    input  logic                               pl_valid_i,
    output logic                               pl_ready_o,
    input  logic                               busy_i,
    output logic [7:0]                         tx_data_o,
    output logic                               pkt_valid_o,
    output logic                               done_o
);

    localparam int LW    = $clog2(MAX_LEN + 1);
    // One spare entry so every LW-bit index addresses real storage.
    localparam int DEPTH = 1 << LW;

    // IDLE: wait request | LOAD: fill buffer | HEADER/PAYLOAD/PARITY: drive router
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY
    } state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [1:0]      addr_q, addr_d;
    logic [7:0]      parity_q, parity_d;
    logic [LW-1:0]   wr_q, wr_d;
    logic [LW-1:0]   rd_q, rd_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            pkt_valid_q, pkt_valid_d;
    logic            req_ready_q, req_ready_d;
    logic            pl_ready_q, pl_ready_d;
    logic            req_err_q, req_err_d;
    logic            done_q, done_d;
    logic            buf_we;
    logic [7:0]      buf_q [DEPTH];

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        addr_d      = addr_q;
        parity_d    = parity_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        tx_data_d   = tx_data_q;
        pkt_valid_d = pkt_valid_q;
        req_err_d   = 1'b0;
        done_d      = 1'b0;
        buf_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (dest_addr_i != 2'd3 && pay_len_i != '0) begin
                        len_d    = pay_len_i;
                        addr_d   = dest_addr_i;
                        parity_d = {pay_len_i, dest_addr_i};
                        wr_d     = '0;
                        rd_d     = '0;
                        state_d  = S_LOAD;
                    end else begin
                        req_err_d = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                if (pl_valid_i && pl_ready_q) begin
                    buf_we   = 1'b1;
                    wr_d     = wr_q + LW'(1);
                    parity_d = parity_q ^ pl_data_i;
                    if (wr_q == len_q - LW'(1)) begin
                        tx_data_d   = {len_q, addr_q};
                        pkt_valid_d = 1'b1;
                        state_d     = S_HEADER;
                    end
                end
            end

            S_HEADER: begin
                if (!busy_i) begin
                    tx_data_d = buf_q[0];
                    rd_d      = LW'(1);
                    state_d   = S_PAYLOAD;
                end
            end

            S_PAYLOAD: begin
                if (!busy_i) begin
                    if (rd_q < len_q) begin
                        tx_data_d = buf_q[rd_q];
                        rd_d      = rd_q + LW'(1);
                    end else begin
                        tx_data_d   = parity_q;
                        pkt_valid_d = 1'b0;
                        state_d     = S_PARITY;
                    end
                end
            end

            S_PARITY: begin
                if (!busy_i) begin
                    tx_data_d = 8'h00;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
        pl_ready_d  = (state_d == S_LOAD);
    end

    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            addr_q      <= 2'd0;
            parity_q    <= 8'h00;
            wr_q        <= '0;
            rd_q        <= '0;
            tx_data_q   <= 8'h00;
            pkt_valid_q <= 1'b0;
            req_ready_q <= 1'b0;
            pl_ready_q  <= 1'b0;
            req_err_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            parity_q    <= parity_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            tx_data_q   <= tx_data_d;
            pkt_valid_q <= pkt_valid_d;
            req_ready_q <= req_ready_d;
            pl_ready_q  <= pl_ready_d;
            req_err_q   <= req_err_d;
            done_q      <= done_d;
        end
    end

    // Payload storage needs no reset; contents are rewritten before every read.
    always_ff @(posedge clock_i) begin
        if (resetn_i && buf_we) begin
            buf_q[wr_q] <= pl_data_i;
        end
    end

    assign req_ready_o = req_ready_q;
    assign req_err_o   = req_err_q;
    assign pl_ready_o  = pl_ready_q;
    assign tx_data_o   = tx_data_q;
    assign pkt_valid_o = pkt_valid_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: directed and random packets compared
// against an expected byte stream built from the packet format rules.
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [1:0] dest_addr = 2'd0;
    logic [5:0] pay_len = 6'd0;
    logic [7:0] pl_data = 8'h00;
    logic       pl_valid = 1'b0;
    logic       busy = 1'b0;
    logic       req_ready, req_err, pl_ready, pkt_valid, done;
    logic [7:0] tx_data;

    int total = 0;
    int bad = 0;
    logic [7:0] pay [64];

    router_pkt_tx #(.MAX_LEN(63)) dut (
        .clock_i    (clock),
        .resetn_i   (resetn),
        .start_i    (start),
        .dest_addr_i(dest_addr),
        .pay_len_i  (pay_len),
        .req_ready_o(req_ready),
        .req_err_o  (req_err),
        .pl_data_i  (pl_data),
        .pl_valid_i (pl_valid),
        .pl_ready_o (pl_ready),
        .busy_i     (busy),
        .tx_data_o  (tx_data),
        .pkt_valid_o(pkt_valid),
        .done_o     (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
    endtask

    // src_mode: 0 always valid, 1 two-cycle gap after 2 bytes, 2 random valid
    // busy_mode: 0 never, 1 busy_len cycles at stream index busy_pos, 2 random
    task automatic send(input logic [1:0] a, input int n, input int src_mode,
                        input int busy_mode, input int busy_pos, input int busy_len,
                        input int abort_at);
        logic [7:0] exp_q [$];
        logic [7:0] par;
        logic [7:0] hdr;
        logic       v;
        logic       b;
        int acc, k, cyc, bcnt, gap;

        chk("req_ready_idle", req_ready, 1);
        start = 1'b1;
        dest_addr = a;
        pay_len = n[5:0];
        @(negedge clock);
        start = 1'b0;
        dest_addr = 2'($urandom);
        pay_len = 6'($urandom);
        chk("pl_ready_after_start", pl_ready, 1);
        chk("req_ready_after_start", req_ready, 0);
        chk("req_err_legal", req_err, 0);

        acc = 0; cyc = 0; gap = 0;
        while (acc < n && cyc < 2000) begin
            if (src_mode == 1) v = !(acc == 2 && gap < 2);
            else if (src_mode == 2) v = ($urandom_range(0, 1) == 1);
            else v = 1'b1;
            if (!v) gap++;
            pl_valid = v;
            pl_data = v ? pay[acc] : 8'($urandom);
            busy = 1'($urandom);
            start = 1'($urandom);
            chk("pkt_valid_in_load", pkt_valid, 0);
            chk("pl_ready_in_load", pl_ready, 1);
            @(negedge clock);
            if (v) acc++;
            cyc++;
        end
        pl_valid = 1'b0;
        busy = 1'b0;
        start = 1'b0;
        if (acc < n) begin
            chk("load_timeout", acc, n);
            return;
        end

        hdr = {n[5:0], a};
        par = hdr;
        exp_q.push_back(hdr);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pay[i]);
            par ^= pay[i];
        end
        exp_q.push_back(par);

        k = 0; cyc = 0; bcnt = 0;
        while (k < n + 2 && cyc < 2000) begin
            if (k == abort_at) begin
                resetn = 1'b0;
                busy = 1'($urandom);
                @(negedge clock);
                resetn = 1'b1;
                busy = 1'b0;
                chk("rst_pkt_valid", pkt_valid, 0);
                chk("rst_tx_data", tx_data, 0);
                chk("rst_req_ready_low", req_ready, 0);
                chk("rst_done", done, 0);
                @(negedge clock);
                chk("post_rst_req_ready", req_ready, 1);
                chk("post_rst_pkt_valid", pkt_valid, 0);
                chk("post_rst_tx_data", tx_data, 0);
                chk("post_rst_pl_ready", pl_ready, 0);
                return;
            end
            chk("tx_data", tx_data, exp_q[k]);
            chk("pkt_valid", pkt_valid, (k <= n));
            chk("done_low_in_tx", done, 0);
            chk("pl_ready_low_in_tx", pl_ready, 0);
            if (busy_mode == 1) b = (k == busy_pos && bcnt < busy_len);
            else if (busy_mode == 2) b = ($urandom_range(0, 3) == 0);
            else b = 1'b0;
            busy = b;
            start = 1'($urandom);
            @(negedge clock);
            if (b) bcnt++;
            else k++;
            cyc++;
        end
        busy = 1'b0;
        start = 1'b0;
        chk("tx_cycles", cyc, n + 2 + bcnt);
        chk("done_pulse", done, 1);
        chk("req_ready_at_done", req_ready, 1);
        chk("tx_data_after_parity", tx_data, 0);
        chk("pkt_valid_after_parity", pkt_valid, 0);
    endtask

    task automatic illegal(input logic [1:0] a, input logic [5:0] n);
        start = 1'b1;
        dest_addr = a;
        pay_len = n;
        @(negedge clock);
        start = 1'b0;
        chk("req_err_pulse", req_err, 1);
        chk("pl_ready_illegal", pl_ready, 0);
        chk("pkt_valid_illegal", pkt_valid, 0);
        chk("req_ready_illegal", req_ready, 1);
        @(negedge clock);
        chk("req_err_one_cycle", req_err, 0);
        chk("pl_ready_stays_low", pl_ready, 0);
        chk("pkt_valid_stays_low", pkt_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_tx_data", tx_data, 0);
        chk("reset_pkt_valid", pkt_valid, 0);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_pl_ready", pl_ready, 0);
        chk("reset_req_err", req_err, 0);
        chk("reset_done", done, 0);
        resetn = 1'b1;
        @(negedge clock);
        chk("req_ready_after_reset", req_ready, 1);

        for (int i = 0; i < 5; i++) pay[i] = 8'h11 + 8'(i);
        send(2'd2, 5, 0, 0, 0, 0, -1);
        @(negedge clock);
        chk("done_single_pulse", done, 0);

        fill_random();
        send(2'd1, 14, 0, 1, 4, 3, -1);
        @(negedge clock);

        illegal(2'd3, 6'd9);
        illegal(2'd1, 6'd0);

        fill_random();
        send(2'd0, 16, 0, 0, 0, 0, 6);
        for (int i = 0; i < 5; i++) pay[i] = 8'hA0 + 8'(i);
        send(2'd1, 5, 0, 0, 0, 0, -1);
        @(negedge clock);

        fill_random();
        send(2'd0, 63, 0, 2, 0, 0, -1);
        fill_random();
        send(2'd2, 5, 0, 1, 0, 2, -1);
        @(negedge clock);
        chk("done_low_after_b2b", done, 0);

        fill_random();
        send(2'd1, 5, 1, 0, 0, 0, -1);
        @(negedge clock);

        fill_random();
        send(2'd0, 1, 0, 1, 2, 2, -1);
        @(negedge clock);

        for (int r = 0; r < 8; r++) begin
            fill_random();
            send(2'($urandom_range(0, 2)), int'($urandom_range(1, 63)), 2, 2, 0, 0, -1);
            if ($urandom_range(0, 1) == 1) @(negedge clock);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet transmitter for the 1x3 router's input port. It accepts a transmit request (destination address and payload length) and the payload bytes from a local source, buffering them internally. It then drives the router's `data_in`/`pkt_valid` input as header, payload and parity bytes, stalling while the router asserts `busy`. It sits upstream of `router_top` and is the RTL counterpart of the bench packet generators.

## Interface
- `MAX_LEN`, 63: maximum payload length in bytes. This is fixed by the 6-bit length field and the buffer depth.
- `clock`  in  1  single clock; all state updates on posedge.
- `resetn`  in  1  synchronous, active-low reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `dest_addr`  in  2  destination port 0..2; value 3 is illegal.
- `pay_len`  in  6  payload length, 1..63; 0 is illegal.
- `req_ready`  out  1  high in IDLE only.
- `req_err`  out  1  one-cycle pulse when an illegal request is rejected.
- `pl_data`  in  8  payload byte from the source.
- `pl_valid`  in  1  `pl_data` is valid.
- `pl_ready`  out  1  high in LOAD; a byte is taken on an edge with `pl_valid & pl_ready`.
- `busy`  in  1  router busy; driven by the router.
- `tx_data`  out  8  byte to the router's `data_in`.
- `pkt_valid`  out  1  to the router's `pkt_valid`; high for the header and payload, low for parity.
- `done`  out  1  one-cycle pulse after the router takes the parity byte.

## Operation
- States: IDLE, LOAD, HEADER, PAYLOAD, PARITY.
- All outputs are registered.
- **IDLE**
  - `req_ready`=1.
  - When `start`=1 and the request is legal (`dest_addr`!=3, `pay_len`!=0):
    - latch `len`=`pay_len` and `addr`=`dest_addr`;
    - set `parity`={`pay_len`,`dest_addr`};
    - clear the write and read indices;
    - go to LOAD.
  - When `start`=1 and the request is illegal: pulse `req_err` and stay in IDLE.
- **LOAD**
  - `pl_ready`=1.
  - On each accepted byte: `buf[wr]`<=`pl_data`, `wr`++, `parity`^=`pl_data`.
  - On the edge that accepts byte number `len`:
    - `pl_ready`<=0;
    - `tx_data`<={`len`,`addr`};
    - `pkt_valid`<=1;
    - go to HEADER.
  - The parity update for this last byte also lands on this edge.
- **Transfer rule:** the router takes the byte on `tx_data` on any edge in HEADER, PAYLOAD or PARITY where `busy`=0. While `busy`=1, `tx_data` and `pkt_valid` hold their values.
- **HEADER**
  - When the header is taken: `tx_data`<=`buf[0]`, `rd`<=1, go to PAYLOAD.
- **PAYLOAD**
  - When a byte is taken and `rd`<`len`: `tx_data`<=`buf[rd]`, `rd`++.
  - When a byte is taken and `rd`==`len`: `tx_data`<=`parity`, `pkt_valid`<=0, go to PARITY.
- **PARITY**
  - When the parity byte is taken: `tx_data`<=0, `done`<=1 for one cycle, go to IDLE.
- Parity is the 8-bit XOR of the header byte and every payload byte.
- `start` is ignored outside IDLE.
- `busy` is ignored in IDLE and LOAD.
- **Reset (any state, including mid-packet):** the next state is IDLE; the buffer contents are don't-care.
  - Reset values: `tx_data`=0, `pkt_valid`=0, `req_ready`=0 during reset and 1 from the first cycle after, `pl_ready`=0, `req_err`=0, `done`=0.
  - A packet aborted by reset is not resumed.

## Timing
- **Request:** `start` accepted at edge N. `pl_ready` is high from N+1. `req_err`, when raised, is high for the cycle after N only.
- **Load:** one byte per cycle at most; load time is `len` cycles plus any source stall.
- **Header:** visible the cycle after the last payload byte is accepted. There are no idle cycles between LOAD and HEADER.
- **Transmit:** with `busy`=0 throughout, the header, `len` payload bytes and the parity byte occupy exactly `len`+2 consecutive cycles.
  - `pkt_valid` is high for `len`+1 cycles, then low for the parity cycle.
  - `done` is high in the cycle after the parity cycle. `req_ready` rises in that same cycle.
- **Stall:** each cycle with `busy`=1 in HEADER, PAYLOAD or PARITY extends the packet by one cycle. No byte is skipped or repeated.
- **Back-to-back:** the earliest next `start` is the `done` cycle. The router's parity-check busy period then stalls the next header naturally.

## Test plan
- **Basic:** request addr=2, len=5; load bytes 0x11..0x15; `busy`=0.
  - Required: `tx_data` sequence 0x16, 0x11, 0x12, 0x13, 0x14, 0x15, parity 0x16^0x11^0x12^0x13^0x14^0x15 = 0x07.
  - `pkt_valid` is 1 for 6 cycles, then 0. `done` pulses once.
- **Busy stall:** addr=1, len=14; hold `busy`=1 for 3 cycles while the 4th payload byte is on `tx_data`.
  - Required: that byte is held for 3 extra cycles; total transmit time is 19 cycles; parity is correct.
- **Illegal request:** `start` with addr=3 (any len), then `start` with len=0.
  - Required: `req_err` pulses once per request; `pl_ready` stays 0; `pkt_valid` is never asserted.
- **Reset mid-packet:** `resetn`=0 for one cycle while in PAYLOAD with len=16 and addr=0.
  - Required: the next cycle shows `pkt_valid`=0, `tx_data`=0, `req_ready`=1. A fresh len=5 packet then completes correctly.
- **Max length and back-to-back with the real router:** connect to `router_top`; send len=63 to addr=0, then an immediate len=5 to addr=2, with the read enables driven.
  - Required: both packets are delivered intact, with router `err`=0 throughout.
- **Source stall:** deassert `pl_valid` for 2 cycles mid-LOAD.
  - Required: no byte is lost, and the header appears only after the 5th accepted byte.
